// File: rtl/linear_kv_psum_arbiter_if.sv
// Request/grant handshake and Psum stream shared by the K/V slaves, the arbiter and the
// downstream LIF input buffer. The arbiter uses the master modport; the slaves use the slave modport.
interface linear_kv_psum_arbiter_if #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned PSUM_W = 80,
    parameter int unsigned CRED_W = 10,
    parameter int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ-1:0]        o_grant;
    logic [N_REQ-1:0]        i_psum_valid;
    logic [N_REQ*PSUM_W-1:0] i_psum_data;
    logic [CRED_W-1:0]       i_down_space;
    logic                    o_valid;
    logic [PSUM_W-1:0]       o_data;
    logic [IDX_W-1:0]        o_src_id;
    logic                    o_last;

    modport master (
        input  i_req, i_psum_valid, i_psum_data, i_down_space,
        output o_grant, o_valid, o_data, o_src_id, o_last
    );

    modport slave (
        output i_req, i_psum_valid, i_psum_data, i_down_space,
        input  o_grant, o_valid, o_data, o_src_id, o_last
    );
endinterface

// File: rtl/linear_kv_psum_arbiter.sv
// Round-robin, whole-tile-lock arbiter sharing one Psum write port between the linear-K and
// linear-V systolic slaves; forwards the granted stream with one register stage and a source tag.
module linear_kv_psum_arbiter #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned PSUM_W   = 80,
    parameter int unsigned TILE_LEN = 256,
    parameter int unsigned CRED_W   = 10,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                            s_clk,
    input  logic                            s_rst,
    linear_kv_psum_arbiter_if.master        bus,
    output logic                            o_busy,
    output logic                            o_err
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TILE_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [CRED_W:0]   TILE_CRED = (CRED_W + 1)'(TILE_LEN);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_STREAM, S_RELEASE} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   r_gidx;
    logic [N_REQ-1:0]   r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_valid;
    logic [PSUM_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_src;
    logic               r_last;
    logic               r_err;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_rr_next;
    logic [N_REQ-1:0]   w_gmask;
    logic               w_gvalid;
    logic [PSUM_W-1:0]  w_gdata;
    logic               w_active;
    logic               w_stray;
    logic               w_credit_ok;

    // First requester at or after the rr pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        w_idx   = r_rr;
        for (int off = 0; off < int'(N_REQ); off++) begin
            w_idx = IDX_W'((int'(r_rr) + off) % int'(N_REQ));
            if (!w_found && bus.i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int n = 0; n < int'(N_REQ); n++) begin
            if (r_gidx == IDX_W'(n)) w_gdata = bus.i_psum_data[n*PSUM_W +: PSUM_W];
        end
    end

    assign w_rr_next   = IDX_W'((int'(r_gidx) + 1) % int'(N_REQ));
    assign w_gmask     = N_REQ'(1) << r_gidx;
    assign w_active    = (r_state == S_GRANT) || (r_state == S_STREAM);
    assign w_gvalid    = w_active && bus.i_psum_valid[r_gidx];
    assign w_stray     = w_active ? |(bus.i_psum_valid & ~w_gmask) : |bus.i_psum_valid;
    assign w_credit_ok = {1'b0, bus.i_down_space} >= TILE_CRED;

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (w_stray) r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_found && w_credit_ok) begin
                        r_gidx  <= w_pick;
                        r_grant <= N_REQ'(1) << w_pick;
                        r_cnt   <= '0;
                        r_tmo   <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT, S_STREAM: begin
                    if (w_gvalid) begin
                        r_valid <= 1'b1;
                        r_data  <= w_gdata;
                        r_src   <= r_gidx;
                        r_last  <= (r_cnt == CNT_LAST);
                        if (r_cnt == CNT_LAST) begin
                            r_grant <= '0;
                            r_state <= S_RELEASE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_STREAM;
                        end
                    end else if (r_state == S_GRANT) begin
                        // Slave never started its readout: give up and move the pointer on.
                        if (r_tmo == TMO_LAST) begin
                            r_err   <= 1'b1;
                            r_grant <= '0;
                            r_rr    <= w_rr_next;
                            r_state <= S_IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    r_rr    <= w_rr_next;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_grant  = r_grant;
    assign bus.o_valid  = r_valid;
    assign bus.o_data   = r_data;
    assign bus.o_src_id = r_src;
    assign bus.o_last   = r_last;
    assign o_busy       = (r_state != S_IDLE);
    assign o_err        = r_err;
endmodule

// File: tb/tb_linear_kv_psum_arbiter.sv
// Directed-sequence bench with random Psum data and gaps; expectations come from a small
// round-robin / tile-count model of the arbiter's observable behaviour.
module tb_linear_kv_psum_arbiter;
    localparam int unsigned N_REQ    = 2;
    localparam int unsigned PSUM_W   = 80;
    localparam int unsigned TILE_LEN = 256;
    localparam int unsigned CRED_W   = 10;
    localparam int unsigned TIMEOUT  = 64;

    logic s_clk;
    logic s_rst;
    logic o_busy;
    logic o_err;

    int n_total = 0;
    int n_pass  = 0;
    int m_rr    = 0;
    bit m_err   = 1'b0;

    linear_kv_psum_arbiter_if #(.N_REQ(N_REQ), .PSUM_W(PSUM_W), .CRED_W(CRED_W)) bus ();

    linear_kv_psum_arbiter #(
        .N_REQ(N_REQ), .PSUM_W(PSUM_W), .TILE_LEN(TILE_LEN), .CRED_W(CRED_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .s_clk (s_clk),
        .s_rst (s_rst),
        .bus   (bus),
        .o_busy(o_busy),
        .o_err (o_err)
    );

    initial begin
        s_clk = 1'b0;
        forever #5 s_clk = ~s_clk;
    end

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin choice: first requester at or after the pointer, -1 if none.
    function automatic int pick(input logic [1:0] req, input int rr);
        for (int off = 0; off < 2; off++) begin
            if (req[(rr + off) % 2]) return (rr + off) % 2;
        end
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int g);
        logic [1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [PSUM_W-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PSUM_W-1:0];
    endfunction

    task automatic wait_grant(output int waited);
        waited = 0;
        while (bus.o_grant == '0 && waited < 100) begin
            step();
            waited++;
        end
    endtask

    // Plays slave g for one full tile; optionally the other slave fires a stray word.
    task automatic burst(input int g, input int stray_at, input string tag);
        logic [PSUM_W-1:0] d;
        for (int i = 0; i < int'(TILE_LEN); i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.i_psum_valid = '0;
                step();
                check({tag, "_gap_valid"}, bus.o_valid, 1'b0);
            end
            d = rand_word();
            bus.i_psum_valid = '0;
            bus.i_psum_valid[g] = 1'b1;
            bus.i_psum_data[g*PSUM_W +: PSUM_W] = d;
            if (i == stray_at) begin
                bus.i_psum_valid[1-g] = 1'b1;
                bus.i_psum_data[(1-g)*PSUM_W +: PSUM_W] = 80'hDEAD;
                m_err = 1'b1;
            end
            step();
            check({tag, "_valid"}, bus.o_valid, 1'b1);
            check({tag, "_data"}, bus.o_data, d);
            check({tag, "_src"}, bus.o_src_id, g[0]);
            check({tag, "_last"}, bus.o_last, (i == int'(TILE_LEN) - 1));
            check({tag, "_grant"}, bus.o_grant, (i == int'(TILE_LEN) - 1) ? 2'b00 : onehot(g));
        end
        bus.i_psum_valid = '0;
        m_rr = (g + 1) % 2;
        step();
        check({tag, "_post_valid"}, bus.o_valid, 1'b0);
        check({tag, "_post_grant"}, bus.o_grant, 2'b00);
        check({tag, "_post_busy"}, o_busy, 1'b0);
        check({tag, "_post_err"}, o_err, m_err);
    endtask

    initial begin
        int w;
        int g;
        logic [PSUM_W-1:0] d;

        s_rst = 1'b1;
        bus.i_req = '0;
        bus.i_psum_valid = '0;
        bus.i_psum_data = '0;
        bus.i_down_space = '0;
        step();
        step();
        s_rst = 1'b0;
        check("rst_grant", bus.o_grant, 2'b00);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_last", bus.o_last, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_err", o_err, 1'b0);

        // Single K tile.
        bus.i_req = 2'b01;
        bus.i_down_space = 10'd300;
        step();
        check("t2_grant", bus.o_grant, onehot(pick(2'b01, m_rr)));
        bus.i_req = '0;
        burst(0, -1, "t2");

        // Both requesting from reset: K, V, K with no overlap.
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        m_rr = 0;
        bus.i_req = 2'b11;
        for (int b = 0; b < 3; b++) begin
            g = pick(bus.i_req, m_rr);
            wait_grant(w);
            check("t3_grant", bus.o_grant, onehot(g));
            if (b == 2) bus.i_req = '0;
            burst(g, -1, "t3");
        end

        // Credit gate.
        bus.i_req = 2'b10;
        bus.i_down_space = 10'd255;
        for (int c = 0; c < 20; c++) begin
            step();
            check("t4_nogrant", bus.o_grant, 2'b00);
        end
        bus.i_down_space = 10'd256;
        step();
        check("t4_grant", bus.o_grant, onehot(pick(2'b10, m_rr)));
        bus.i_req = '0;
        burst(1, -1, "t4");

        // Timeout on K, V pending.
        bus.i_req = 2'b11;
        bus.i_down_space = 10'd300;
        step();
        g = pick(2'b11, m_rr);
        check("t5_grant_k", bus.o_grant, onehot(g));
        bus.i_req = 2'b10;
        for (int c = 0; c < int'(TIMEOUT) - 1; c++) step();
        check("t5_hold_grant", bus.o_grant, onehot(g));
        check("t5_hold_err", o_err, 1'b0);
        step();
        m_err = 1'b1;
        m_rr = (g + 1) % 2;
        check("t5_drop_grant", bus.o_grant, 2'b00);
        check("t5_err", o_err, m_err);
        step();
        check("t5_grant_v", bus.o_grant, onehot(pick(2'b10, m_rr)));

        // Reset in the middle of the V stream.
        for (int i = 0; i < 10; i++) begin
            d = rand_word();
            bus.i_psum_valid = 2'b10;
            bus.i_psum_data[PSUM_W +: PSUM_W] = d;
            step();
            check("t1_valid", bus.o_valid, 1'b1);
            check("t1_data", bus.o_data, d);
        end
        #2;
        s_rst = 1'b1;
        #1;
        check("t1_async_grant", bus.o_grant, 2'b00);
        check("t1_async_valid", bus.o_valid, 1'b0);
        check("t1_async_busy", o_busy, 1'b0);
        bus.i_psum_valid = '0;
        bus.i_req = '0;
        step();
        s_rst = 1'b0;
        m_rr = 0;
        m_err = 1'b0;
        check("t1_err_clr", o_err, m_err);
        bus.i_req = 2'b11;
        step();
        check("t1_rr_reset", bus.o_grant, onehot(pick(2'b11, m_rr)));
        bus.i_req = '0;

        // Stray V word during a K burst.
        burst(0, 100, "t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
